// File: rtl/data_mem_resp.sv
// -----------------------------------------------------------------------------
// data_mem_resp
//   Data-memory responder for the memory stage of the PIGRO pipeline. It serves
//   STR (write) and LDW (read) accesses against a 2^AW x DW register-array
//   memory. Writes are posted into a small FIFO and retire to the array one per
//   cycle. Reads return registered data one cycle after the request. A read
//   first looks in the pending writes, and the youngest matching entry wins.
//
// Parameters
//   AW     address width; the memory holds 2^AW words
//   DW     data word width (raw bits)
//   DEPTH  posted-write queue entries (1..4)
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active-high
//   wr_en     in   write request
//   wr_addr   in   write word address
//   wr_data   in   write data
//   wr_ready  out  queue can accept a write this cycle
//   rd_en     in   read request
//   rd_addr   in   read word address
//   rd_data   out  registered read data
//   rd_valid  out  rd_data valid, one-cycle pulse per read
//   q_empty   out  no posted writes pending
// -----------------------------------------------------------------------------
module data_mem_resp #(
    parameter int AW    = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          q_empty
);

    localparam int WORDS = 1 << AW;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_entry_t;

    // Shift-register FIFO: entry 0 is always the oldest (the head), and
    // entries 0..count-1 are valid. A higher index means a younger write.
    wr_entry_t     q_q [DEPTH];
    wr_entry_t     q_d [DEPTH];
    logic [CW-1:0] count_q, count_d;

    logic [DW-1:0] mem_q [WORDS];

    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q;
    logic [DW-1:0] rd_word;

    logic          push;
    logic          pop;

    // The ready signal looks only at the registered count. A pop in the same
    // cycle does not free a slot for the incoming write.
    assign wr_ready = (count_q != CW'(DEPTH));
    assign push     = wr_en && wr_ready;
    // The pop decision comes from the count before the edge. A write accepted
    // into an empty queue therefore cannot retire at the same edge.
    assign pop      = (count_q != '0);
    assign q_empty  = (count_q == '0);

    // NOTE: combinational blocks assign every output a default first, so no
    // path through the branches can leave a value held (no latch).
    always_comb begin
        q_d     = q_q;
        count_d = count_q;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                q_d[i] = q_q[i + 1];
            end
            count_d = count_q - CW'(1);
        end
        // After any pop, count_d is exactly the first free slot, so push and
        // pop together keep FIFO order with the count unchanged.
        if (push) begin
            q_d[count_d] = '{addr: wr_addr, data: wr_data};
            count_d      = count_d + CW'(1);
        end
    end

    // Read-after-write bypass uses the queue state before the edge. Scanning
    // from oldest to youngest makes the youngest match win. The head entry
    // that drains at this edge still takes part.
    always_comb begin
        rd_word = mem_q[rd_addr];
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (q_q[i].addr == rd_addr)) begin
                rd_word = q_q[i].data;
            end
        end
        rd_data_d = rd_en ? rd_word : rd_data_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_q[i] <= '0;
            end
            // NOTE: the array is reset on purpose. After reset, a read of any
            // address must return 0. That costs a reset net on every word.
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            q_q        <= q_d;
            rd_valid_q <= rd_en;
            rd_data_q  <= rd_data_d;
            if (pop) begin
                mem_q[q_q[0].addr] <= q_q[0].data;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// -----------------------------------------------------------------------------
// tb_data_mem_resp
//   Directed bench for data_mem_resp. Each read pushes its expected word to a
//   scoreboard queue. The word is popped and compared when rd_valid should
//   appear. A second instance with DEPTH=1 exercises back-pressure. In the
//   default DEPTH=2 instance the queue drains one entry per cycle, so it never
//   fills.
// -----------------------------------------------------------------------------
module tb_data_mem_resp;

    logic        clk = 1'b0;
    logic        rst;

    logic        wr_en, rd_en;
    logic [3:0]  wr_addr, rd_addr;
    logic [31:0] wr_data, rd_data;
    logic        wr_ready, rd_valid, q_empty;

    logic        d1_wr_en, d1_rd_en;
    logic [3:0]  d1_wr_addr, d1_rd_addr;
    logic [31:0] d1_wr_data, d1_rd_data;
    logic        d1_wr_ready, d1_rd_valid, d1_q_empty;

    int          n_total  = 0;
    int          n_passed = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    data_mem_resp #(.AW(4), .DW(32), .DEPTH(2)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .q_empty  (q_empty)
    );

    data_mem_resp #(.AW(4), .DW(32), .DEPTH(1)) u_d1 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (d1_wr_en),
        .wr_addr  (d1_wr_addr),
        .wr_data  (d1_wr_data),
        .wr_ready (d1_wr_ready),
        .rd_en    (d1_rd_en),
        .rd_addr  (d1_rd_addr),
        .rd_data  (d1_rd_data),
        .rd_valid (d1_rd_valid),
        .q_empty  (d1_q_empty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic re, input logic [3:0] ra);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
    endtask

    // One clock on the main instance. Outputs are sampled 1 time unit after the
    // edge. A read issued before the edge must show rd_valid, with data equal
    // to the scoreboard head.
    task automatic tick(input string tag);
        logic        was_rd;
        logic [31:0] exp;
        was_rd = rd_en;
        @(posedge clk);
        #1;
        check({tag, "_rd_valid"}, {31'b0, rd_valid}, {31'b0, was_rd});
        if (was_rd && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check({tag, "_rd_data"}, rd_data, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        d1_wr_en = 1'b0; d1_wr_addr = '0; d1_wr_data = '0;
        d1_rd_en = 1'b0; d1_rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("rst_rd_data",  rd_data,           32'd0);
        check("rst_q_empty",  {31'b0, q_empty},  32'd1);
        rst = 1'b0;
        #1;
        check("rst_wr_ready", {31'b0, wr_ready}, 32'd1);

        // 1: read after reset returns 0 as a single-cycle pulse.
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd5); exp_q.push_back(32'd0); tick("t1");
        check("t1_q_empty", {31'b0, q_empty}, 32'd1);
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0); tick("t1_idle");

        // 2: write 0xAB to addr 3, then read it back from the array.
        drive(1'b1, 4'd3, 32'h0000_00AB, 1'b0, 4'd0); tick("t2_wr");
        check("t2_q_pending", {31'b0, q_empty}, 32'd0);
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0); tick("t2_drain");
        check("t2_q_drained", {31'b0, q_empty}, 32'd1);
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd3); exp_q.push_back(32'h0000_00AB); tick("t2_rd");
        check("t2_q_empty", {31'b0, q_empty}, 32'd1);
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0); tick("t2_hold");
        check("t2_rd_hold", rd_data, 32'h0000_00AB);

        // 3: bypass of a queued -16 before it reaches the array.
        drive(1'b1, 4'd7, 32'hFFFF_FFF0, 1'b0, 4'd0); tick("t3_wr");
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd7); exp_q.push_back(32'hFFFF_FFF0); tick("t3_byp");

        // A write and a read to the same address at one edge: the read sees the
        // old value. The next read sees the new one through bypass.
        drive(1'b1, 4'd3, 32'h0000_0055, 1'b1, 4'd3); exp_q.push_back(32'h0000_00AB); tick("same_edge");
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd3); exp_q.push_back(32'h0000_0055); tick("next_edge");

        // 4: back-to-back writes to addr 2, youngest value wins.
        drive(1'b1, 4'd2, 32'd1, 1'b0, 4'd0); tick("t4_wr1");
        drive(1'b1, 4'd2, 32'd2, 1'b0, 4'd0); tick("t4_wr2");
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd2); exp_q.push_back(32'd2); tick("t4_byp");
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0); tick("t4_idle");
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd2); exp_q.push_back(32'd2); tick("t4_arr");

        // 5: three consecutive writes. With DEPTH=2 and one drain per cycle,
        // wr_ready stays high throughout.
        drive(1'b1, 4'd10, 32'h0000_00A0, 1'b0, 4'd0);
        check("t5_ready0", {31'b0, wr_ready}, 32'd1); tick("t5_w0");
        drive(1'b1, 4'd11, 32'h0000_00A1, 1'b0, 4'd0);
        check("t5_ready1", {31'b0, wr_ready}, 32'd1); tick("t5_w1");
        drive(1'b1, 4'd12, 32'h0000_00A2, 1'b0, 4'd0);
        check("t5_ready2", {31'b0, wr_ready}, 32'd1); tick("t5_w2");
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd10); exp_q.push_back(32'h0000_00A0); tick("t5_r0");
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd11); exp_q.push_back(32'h0000_00A1); tick("t5_r1");
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd12); exp_q.push_back(32'h0000_00A2); tick("t5_r2");
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);

        // Back-pressure on the DEPTH=1 instance: the queue is full for one
        // cycle, and a write offered during that cycle is dropped.
        d1_wr_en = 1'b1; d1_wr_addr = 4'd4; d1_wr_data = 32'h11;
        check("d1_ready_init", {31'b0, d1_wr_ready}, 32'd1);
        tick("d1_acc");
        check("d1_full_ready", {31'b0, d1_wr_ready}, 32'd0);
        check("d1_full_empty", {31'b0, d1_q_empty},  32'd0);
        d1_wr_addr = 4'd5; d1_wr_data = 32'h33;
        tick("d1_drop");
        check("d1_free_ready", {31'b0, d1_wr_ready}, 32'd1);
        check("d1_free_empty", {31'b0, d1_q_empty},  32'd1);
        d1_wr_en = 1'b0; d1_rd_en = 1'b1; d1_rd_addr = 4'd5;
        tick("d1_rd5");
        check("d1_rd5_valid", {31'b0, d1_rd_valid}, 32'd1);
        check("d1_rd5_data",  d1_rd_data,           32'd0);
        d1_rd_addr = 4'd4;
        tick("d1_rd4");
        check("d1_rd4_data",  d1_rd_data,           32'h11);
        d1_rd_en = 1'b0;

        // 6: reset while a write is queued and a read is in flight.
        drive(1'b1, 4'd9, 32'h0000_1234, 1'b1, 4'd1); exp_q.push_back(32'd0); tick("t6_pre");
        check("t6_q_pending", {31'b0, q_empty}, 32'd0);
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", {31'b0, rd_valid}, 32'd0);
        check("t6_rst_empty", {31'b0, q_empty},  32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd9); exp_q.push_back(32'd0); tick("t6_rd9");
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd3); exp_q.push_back(32'd0); tick("t6_rd3");
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0); tick("t6_idle");

        check("sb_leftover", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
